// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants used by the divider sequencer
package cpu_pkg;

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BYZERO,
    DIV_ON,
    DIV_END
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Two's-complement magnitude when neg is set, otherwise the value unchanged.
  function automatic logic [31:0] cond_negate32(input logic neg, input logic [31:0] val);
    return neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration of the divider
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // The trial remainder needs one extra bit: it can exceed the divisor by up to 2x.
  assign trial = {rem_i, bit_i};
  assign q_o   = (trial >= {1'b0, divisor_i});
  assign diff  = trial[WIDTH-1:0] - divisor_i;
  assign rem_o = q_o ? diff : trial[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle iterative DIV/DIVU sequencer for the EX stage
module div_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_abs, op2_abs;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] quot_raw;
  logic [WIDTH-1:0] quot_fin, rem_fin;

  logic accept, step_en, finish, hold_result;

  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_nxt),
    .q_o       (q_bit)
  );

  // INT_MIN / -1 falls out naturally: magnitude 2^(W-1) with no negation wraps to INT_MIN.
  assign quot_raw = {dvd_q[WIDTH-2:0], q_bit};
  assign quot_fin = neg_quot_q ? (~quot_raw + 1'b1) : quot_raw;
  assign rem_fin  = neg_rem_q  ? (~rem_nxt + 1'b1)  : rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_FREE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          next_state = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        next_state = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          next_state = DIV_FREE;
        end else if (cnt == CNT_LAST) begin
          next_state = DIV_END;
        end
      end
      DIV_END: begin
        if (annul_i || start_i == DIV_STOP) begin
          next_state = DIV_FREE;
        end
      end
      default: next_state = DIV_FREE;
    endcase
  end

  always_comb begin
    accept      = 1'b0;
    step_en     = 1'b0;
    finish      = 1'b0;
    hold_result = 1'b0;
    case (state)
      DIV_FREE: accept      = (next_state == DIV_ON);
      DIV_ON: begin
        step_en = (next_state != DIV_FREE);
        finish  = (next_state == DIV_END);
      end
      DIV_END:  hold_result = (next_state == DIV_END);
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept) begin
      cnt        <= '0;
      rem_q      <= '0;
      dvd_q      <= op1_abs;
      dvs_q      <= op2_abs;
      neg_quot_q <= op1_neg ^ op2_neg;
      neg_rem_q  <= op1_neg;
    end else if (step_en) begin
      cnt   <= cnt + 1'b1;
      rem_q <= rem_nxt;
      dvd_q <= quot_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_o  <= DIV_RESULT_NOT_READY;
      result_o <= '0;
    end else begin
      ready_o <= (next_state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
      if (finish) begin
        result_o <= {rem_fin, quot_fin};
      end else if (!hold_result) begin
        result_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed vector bench for the iterative divider sequencer
module tb_div_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_err = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Start a divide, measure edges until ready_o, check result, then release start_i.
  task automatic run_div(input string name, input vec_t v, input logic scramble);
    int lat;
    lat = 0;
    signed_div_i = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    start_i      = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (scramble && e == 1) begin
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'h0;
        signed_div_i = ~v.sgn;
      end
      if (ready_o) begin
        lat = e;
        break;
      end
    end
    check({name, " latency"}, 64'(lat), 64'(v.lat));
    check({name, " result"}, result_o, v.res);
    start_i = 1'b0;
    tick();
    check({name, " ready drop"}, {63'd0, ready_o}, 64'd0);
    check({name, " result clear"}, result_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int hi_seen;

    vecs[0]  = '{1'b0, 32'd7,          32'd2,          {32'h1,        32'h3},         33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1,        32'hFFFF_FFFD}, 33};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,        32'h8000_0000}, 33};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0},        33};
    vecs[5]  = '{1'b0, 32'd100,        32'd7,          {32'h2,        32'hE},         33};
    vecs[6]  = '{1'b0, 32'd5,          32'd0,          64'd0,                         2};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  {32'hFFFF_FFFE, 32'h2},        33};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,        32'hFFFF_FFFF}, 33};
    vecs[9]  = '{1'b0, 32'd3,          32'd10,         {32'h3,        32'h0},         33};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          64'd0,                         2};
    vecs[11] = '{1'b1, 32'h8000_0000,  32'd1,          {32'h0,        32'h8000_0000}, 33};

    // Reset state
    tick();
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset state", 64'(dut.state), 64'(DIV_FREE));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Operands changed after acceptance must not affect the result
    run_div("scramble", vecs[5], 1'b1);

    // Divide by zero with start_i held: ready_o stays high
    signed_div_i = 1'b0;
    opdata1_i    = 32'd9;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    tick();
    check("byzero edge1 ready", {63'd0, ready_o}, 64'd0);
    tick();
    check("byzero edge2 ready", {63'd0, ready_o}, 64'd1);
    hi_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ready_o === 1'b1 && result_o === 64'd0) hi_seen++;
    end
    check("byzero hold", 64'(hi_seen), 64'd5);
    start_i = 1'b0;
    tick();
    check("byzero release", {63'd0, ready_o}, 64'd0);

    // Simultaneous start and annul in FREE: annul wins
    opdata1_i = 32'd7;
    opdata2_i = 32'd2;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    tick();
    check("start+annul state", 64'(dut.state), 64'(DIV_FREE));
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // Annul at the tenth ON edge
    start_i = 1'b1;
    tick();
    for (int c = 0; c < 9; c++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul state", 64'(dut.state), 64'(DIV_FREE));
    hi_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ready_o !== 1'b0) hi_seen++;
    end
    check("annul no ready", 64'(hi_seen), 64'd0);
    run_div("after annul", vecs[5], 1'b0);

    // Async reset mid-ON
    signed_div_i = 1'b0;
    opdata1_i    = 32'd7;
    opdata2_i    = 32'd2;
    start_i      = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    #2 rst = 1'b1;
    #1;
    check("rst midon ready", {63'd0, ready_o}, 64'd0);
    check("rst midon result", result_o, 64'd0);
    check("rst midon state", 64'(dut.state), 64'(DIV_FREE));
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Async reset while a result is being presented clears it between edges
    start_i = 1'b1;
    for (int c = 0; c < 40 && ready_o !== 1'b1; c++) tick();
    check("pre-rst ready", {63'd0, ready_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst end ready", {63'd0, ready_o}, 64'd0);
    check("rst end result", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    run_div("after rst", '{1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
